// File: rtl/instr_loader.sv
// instr_loader: sequential instruction encoder and loader for the single-cycle CPU.
// Accepts symbolic instruction descriptors over a valid/ready handshake.
// Each descriptor is encoded into a 32-bit MIPS word.
// The word is then written big-endian, one byte per cycle, into byte-wide instruction memory.
//
// Parameters:
//   ADDR_W    - instruction-memory byte-address width (capacity 2^(ADDR_W-2) words)
//   BASE_ADDR - byte address of the first word (multiple of 4)
// Ports:
//   CLK, Reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - descriptor handshake
//   in_kind, in_rs, in_rt, in_rd, in_sa, in_imm, in_target - descriptor fields
//   mem_addr, mem_data, mem_wr - byte write port to instruction memory
//   instr_word            - last encoded word
//   count                 - number of words completely written
//   done                  - halt word written
//   full                  - memory filled
//   checksum              - running XOR of written words
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, checksum is accumulated.
// When it is undefined, checksum is tied to zero.
module instr_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic [31:0]       instr_word,
  output logic [ADDR_W-2:0] count,
  output logic              done,
  output logic              full,
  output logic [31:0]       checksum
);

  localparam logic [31:0]       HALT_WORD = 32'hFC00_0000;
  // Capacity in words, 2^(ADDR_W-2), expressed in the width of count.
  localparam logic [ADDR_W-2:0] CAP_WORDS = {1'b1, {(ADDR_W-2){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4,
    DONE = 3'd5,
    FULL = 3'd6
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        byteOff;
  logic [ADDR_W-2:0] countInc;

  // Map a descriptor onto its MIPS machine word; fields the format does not use are forced to zero.
  function automatic logic [31:0] encodeInstr(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sa,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    case (kind)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
      4'd4:    w = {6'b000000, 5'd0, rt, rd, sa, 6'b000000};
      4'd5:    w = {6'b001001, rs, rt, imm};
      4'd6:    w = {6'b001100, rs, rt, imm};
      4'd7:    w = {6'b001101, rs, rt, imm};
      4'd8:    w = {6'b001010, rs, rt, imm};
      4'd9:    w = {6'b101011, rs, rt, imm};
      4'd10:   w = {6'b100011, rs, rt, imm};
      4'd11:   w = {6'b000100, rs, rt, imm};
      4'd12:   w = {6'b000101, rs, rt, imm};
      4'd13:   w = {6'b000001, rs, 5'd0, imm};
      4'd14:   w = {6'b000010, target};
      4'd15:   w = HALT_WORD;
      default: w = HALT_WORD;
    endcase
    return w;
  endfunction

  assign countInc = count + {{(ADDR_W-2){1'b0}}, 1'b1};

  // Next-state and write-port decode.
  // mem_* depend only on registered state, never on in_*.
  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    mem_wr    = 1'b0;
    mem_data  = 8'h00;
    byteOff   = 2'd0;
    case (state)
      IDLE: begin
        in_ready = ~Reset;
        if (in_valid) begin
          stateNext = B0;
        end else begin
          stateNext = IDLE;
        end
      end
      B0: begin
        mem_wr    = 1'b1;
        byteOff   = 2'd0;
        mem_data  = instr_word[31:24];
        stateNext = B1;
      end
      B1: begin
        mem_wr    = 1'b1;
        byteOff   = 2'd1;
        mem_data  = instr_word[23:16];
        stateNext = B2;
      end
      B2: begin
        mem_wr    = 1'b1;
        byteOff   = 2'd2;
        mem_data  = instr_word[15:8];
        stateNext = B3;
      end
      B3: begin
        mem_wr   = 1'b1;
        byteOff  = 2'd3;
        mem_data = instr_word[7:0];
        // Halt takes priority so a halt landing in the last slot still ends in DONE.
        if (instr_word == HALT_WORD) begin
          stateNext = DONE;
        end else if (countInc == CAP_WORDS) begin
          stateNext = FULL;
        end else begin
          stateNext = IDLE;
        end
      end
      DONE:    stateNext = DONE;
      FULL:    stateNext = FULL;
      default: stateNext = IDLE;
    endcase
    mem_addr = ptr + {{(ADDR_W-2){1'b0}}, byteOff};
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Word latch, pointer, count and status flags.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ptr        <= ADDR_W'(BASE_ADDR);
      count      <= '0;
      instr_word <= 32'd0;
      done       <= 1'b0;
      full       <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        instr_word <= encodeInstr(in_kind, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);
      end
      if (state == B3) begin
        ptr   <= ptr + ADDR_W'(4);
        count <= countInc;
        if (instr_word == HALT_WORD) begin
          done <= 1'b1;
        end
        if (countInc == CAP_WORDS) begin
          full <= 1'b1;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksumR;

  // Fold each word in only when its last byte lands, so words aborted by Reset never contribute.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      checksumR <= 32'd0;
    end else if (state == B3) begin
      checksumR <= checksumR ^ instr_word;
    end else begin
      checksumR <= checksumR;
    end
  end

  assign checksum = checksumR;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader.
// Instance dutA uses the default parameters (ADDR_W=8).
// Instance dutB uses ADDR_W=4, which gives 4 words of capacity, to exercise the full and abort paths.
module tb_instr_loader;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        resetA, resetB, validA, validB;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [25:0] target;

  logic        readyA, memWrA, doneA, fullA;
  logic [7:0]  memAddrA, memDataA;
  logic [31:0] wordA, checksumA;
  logic [6:0]  countA;

  logic        readyB, memWrB, doneB, fullB;
  logic [3:0]  memAddrB;
  logic [7:0]  memDataB;
  logic [31:0] wordB, checksumB;
  logic [2:0]  countB;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] memA [256];
  logic [7:0] memB [16];

  instr_loader dutA (
    .CLK(CLK), .Reset(resetA), .in_valid(validA), .in_ready(readyA),
    .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_sa(sa),
    .in_imm(imm), .in_target(target),
    .mem_addr(memAddrA), .mem_data(memDataA), .mem_wr(memWrA),
    .instr_word(wordA), .count(countA), .done(doneA), .full(fullA),
    .checksum(checksumA)
  );

  instr_loader #(.ADDR_W(4), .BASE_ADDR(0)) dutB (
    .CLK(CLK), .Reset(resetB), .in_valid(validB), .in_ready(readyB),
    .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_sa(sa),
    .in_imm(imm), .in_target(target),
    .mem_addr(memAddrB), .mem_data(memDataB), .mem_wr(memWrB),
    .instr_word(wordB), .count(countB), .done(doneB), .full(fullB),
    .checksum(checksumB)
  );

  // Bench-side instruction memories capture every byte strobe.
  always @(posedge CLK) begin
    if (memWrA) memA[memAddrA] <= memDataA;
    if (memWrB) memB[memAddrB] <= memDataB;
  end

  task automatic applyReset(input bit sel);
    @(negedge CLK);
    validA = 1'b0; validB = 1'b0;
    if (sel) resetB = 1'b1; else resetA = 1'b1;
    @(negedge CLK);
    if (sel) resetB = 1'b0; else resetA = 1'b0;
  endtask

  // Present a descriptor and return #1 after the accept edge.
  task automatic send(input bit sel, input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] a, input logic [15:0] im,
                      input logic [25:0] tg, input bit hold);
    int n;
    @(negedge CLK);
    kind = k; rs = s; rt = t; rd = d; sa = a; imm = im; target = tg;
    if (sel) validB = 1'b1; else validA = 1'b1;
    n = 0;
    while (!(sel ? readyB : readyA) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready never rose (sel=%0d)", sel);
    end
    @(posedge CLK);
    #1;
    if (!hold) begin
      if (sel) validB = 1'b0; else validA = 1'b0;
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    resetA = 1'b1;
    #1;
    vectors++;
    if (readyA !== 1'b0) begin miscompares++; $display("FAIL ready_in_reset: got %b want 0", readyA); end
    @(negedge CLK);
    resetA = 1'b0;
    #1;
    vectors++;
    if ({readyA, memWrA, memAddrA, memDataA} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_port: got rdy=%b wr=%b addr=%h data=%h want 1 0 00 00",
               readyA, memWrA, memAddrA, memDataA);
    end
    vectors++;
    if ({wordA, countA, doneA, fullA, checksumA} !== {32'h0, 7'd0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got word=%h cnt=%0d done=%b full=%b cs=%h want zeros",
               wordA, countA, doneA, fullA, checksumA);
    end
  endtask

  task automatic test_addiu;
    logic [31:0] exp;
    exp = 32'h2401_0008;
    applyReset(1'b0);
    send(1'b0, 4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
    vectors++;
    if (wordA !== exp) begin miscompares++; $display("FAIL addiu_word: got %h want %h", wordA, exp); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      vectors++;
      if ({memWrA, memAddrA, memDataA, readyA} !== {1'b1, 8'(k), exp[31-8*k -: 8], 1'b0}) begin
        miscompares++;
        $display("FAIL addiu_byte%0d: got wr=%b addr=%h data=%h rdy=%b want 1 %h %h 0",
                 k, memWrA, memAddrA, memDataA, readyA, 8'(k), exp[31-8*k -: 8]);
      end
    end
    @(negedge CLK);
    vectors++;
    if ({memWrA, readyA, countA} !== {1'b0, 1'b1, 7'd1}) begin
      miscompares++;
      $display("FAIL addiu_after: got wr=%b rdy=%b cnt=%0d want 0 1 1", memWrA, readyA, countA);
    end
  endtask

  task automatic test_rtype;
    logic [31:0] exp;
    applyReset(1'b0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0); exp = 32'h0022_1820; end
        1: begin send(1'b0, 4'd4, 5'd7, 5'd1, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0); exp = 32'h0001_1080; end
        default: begin send(1'b0, 4'd1, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 1'b0); exp = 32'h0022_1822; end
      endcase
      vectors++;
      if (wordA !== exp) begin miscompares++; $display("FAIL rtype%0d_word: got %h want %h", i, wordA, exp); end
      repeat (5) @(negedge CLK);
      vectors++;
      if ({memA[4*i], memA[4*i+1], memA[4*i+2], memA[4*i+3], countA} !== {exp, 7'(i+1)}) begin
        miscompares++;
        $display("FAIL rtype%0d_mem: got %h%h%h%h cnt=%0d want %h cnt=%0d", i,
                 memA[4*i], memA[4*i+1], memA[4*i+2], memA[4*i+3], countA, exp, i+1);
      end
    end
  endtask

  task automatic test_branch;
    logic [31:0] exp;
    applyReset(1'b0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin send(1'b0, 4'd11, 5'd1, 5'd2, 5'd31, 5'd31, 16'hFFFE, 26'h3FF_FFFF, 1'b0); exp = 32'h1022_FFFE; end
        1: begin send(1'b0, 4'd13, 5'd4, 5'd9, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b0); exp = 32'h0480_0003; end
        default: begin send(1'b0, 4'd14, 5'd3, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'd4, 1'b0); exp = 32'h0800_0004; end
      endcase
      vectors++;
      if (wordA !== exp) begin miscompares++; $display("FAIL branch%0d_word: got %h want %h", i, wordA, exp); end
      repeat (5) @(negedge CLK);
      vectors++;
      if ({memA[4*i], memA[4*i+1], memA[4*i+2], memA[4*i+3]} !== exp) begin
        miscompares++;
        $display("FAIL branch%0d_mem: got %h%h%h%h want %h", i,
                 memA[4*i], memA[4*i+1], memA[4*i+2], memA[4*i+3], exp);
      end
    end
  endtask

  task automatic test_halt;
    int wr;
    applyReset(1'b0);
    send(1'b0, 4'd15, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 1'b1);
    repeat (5) @(negedge CLK);
    vectors++;
    if ({wordA, memA[0], memA[1], memA[2], memA[3]} !== {32'hFC00_0000, 32'hFC00_0000}) begin
      miscompares++;
      $display("FAIL halt_word: got %h mem %h%h%h%h want fc000000", wordA, memA[0], memA[1], memA[2], memA[3]);
    end
    vectors++;
    if ({doneA, fullA, readyA, countA} !== {1'b1, 1'b0, 1'b0, 7'd1}) begin
      miscompares++;
      $display("FAIL halt_flags: got done=%b full=%b rdy=%b cnt=%0d want 1 0 0 1", doneA, fullA, readyA, countA);
    end
    wr = 0;
    repeat (10) begin
      @(negedge CLK);
      if (memWrA || readyA) wr++;
    end
    vectors++;
    if (wr !== 0 || countA !== 7'd1) begin
      miscompares++;
      $display("FAIL halt_hold: got %0d active cycles cnt=%0d want 0 cnt=1", wr, countA);
    end
    validA = 1'b0;
  endtask

  task automatic test_full;
    logic [31:0] exp;
    int wr;
    applyReset(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'd7, 5'd0, 5'(i+1), 5'd0, 5'd0, 16'(i), 26'd0, 1'b0);
      case (i)
        0: exp = 32'h3401_0000;
        1: exp = 32'h3402_0001;
        2: exp = 32'h3403_0002;
        default: exp = 32'h3404_0003;
      endcase
      repeat (5) @(negedge CLK);
      vectors++;
      if ({memB[4*i], memB[4*i+1], memB[4*i+2], memB[4*i+3], wordB, countB, fullB} !==
          {exp, exp, 3'(i+1), (i == 3)}) begin
        miscompares++;
        $display("FAIL full_word%0d: got mem %h%h%h%h word=%h cnt=%0d full=%b want %h cnt=%0d", i,
                 memB[4*i], memB[4*i+1], memB[4*i+2], memB[4*i+3], wordB, countB, fullB, exp, i+1);
      end
    end
    @(negedge CLK);
    validB = 1'b1;
    wr = 0;
    repeat (10) begin
      @(negedge CLK);
      if (memWrB || readyB) wr++;
    end
    validB = 1'b0;
    vectors++;
    if ({fullB, doneB, wr == 0, countB} !== {1'b1, 1'b0, 1'b1, 3'd4}) begin
      miscompares++;
      $display("FAIL full_hold: got full=%b done=%b active=%0d cnt=%0d want 1 0 0 4", fullB, doneB, wr, countB);
    end
    // Abort a word with Reset while its second byte is on the bus.
    applyReset(1'b1);
    send(1'b1, 4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if ({memWrB, memAddrB} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL abort_b1: got wr=%b addr=%h want 1 1", memWrB, memAddrB);
    end
    resetB = 1'b1;
    @(negedge CLK);
    resetB = 1'b0;
    #1;
    vectors++;
    if ({memWrB, memAddrB, countB, fullB, checksumB, readyB} !== {1'b0, 4'd0, 3'd0, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_reset: got wr=%b addr=%h cnt=%0d full=%b cs=%h rdy=%b want 0 0 0 0 0 1",
               memWrB, memAddrB, countB, fullB, checksumB, readyB);
    end
    send(1'b1, 4'd6, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b0);
    repeat (5) @(negedge CLK);
    vectors++;
    if ({memB[0], memB[1], memB[2], memB[3], countB} !== {32'h3043_00FF, 3'd1}) begin
      miscompares++;
      $display("FAIL abort_reload: got %h%h%h%h cnt=%0d want 304300ff cnt=1",
               memB[0], memB[1], memB[2], memB[3], countB);
    end
  endtask

  task automatic test_checksum;
    logic [31:0] exp1, exp2;
`ifdef LOADER_CHECKSUM_EN
    exp1 = 32'h2401_0008;
    exp2 = 32'h2423_1828;
`else
    exp1 = 32'h0;
    exp2 = 32'h0;
`endif
    applyReset(1'b0);
    send(1'b0, 4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'd8, 26'd0, 1'b0);
    repeat (5) @(negedge CLK);
    vectors++;
    if (checksumA !== exp1) begin miscompares++; $display("FAIL checksum1: got %h want %h", checksumA, exp1); end
    send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    repeat (5) @(negedge CLK);
    vectors++;
    if (checksumA !== exp2) begin miscompares++; $display("FAIL checksum2: got %h want %h", checksumA, exp2); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetA = 1'b1; resetB = 1'b1; validA = 1'b0; validB = 1'b0;
    kind = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; sa = 5'd0; imm = 16'd0; target = 26'd0;
    applyReset(1'b1);
    test_reset();
    test_addiu();
    test_rtype();
    test_branch();
    test_halt();
    test_full();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
